z88_memarb: RTL and testbench



---
 rtl/z88_memarb_pkg.sv | 27 ++
 rtl/z88_memarb_prio.sv | 55 +++++
 rtl/z88_memarb.sv | 195 +++++++++++++++++++
 tb/tb_z88_memarb.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/z88_memarb_pkg.sv
// z88_memarb_pkg
// Shared types and default timing for the slot-0 SRAM arbiter.
//   state_t  : sequencer states (IDLE, RD, WSETUP, WPULSE, WHOLD)
//   owner_t  : which requester owns the current transaction
//   DEF_*    : default parameter values used by z88_memarb
package z88_memarb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WSETUP = 3'd2,
    WPULSE = 3'd3,
    WHOLD  = 3'd4
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VID = 1'b1
  } owner_t;

  localparam int          DEF_ADDR_W   = 19;
  localparam int          DEF_RD_WAIT  = 2;
  localparam int          DEF_WR_PULSE = 2;
  localparam int          DEF_VID_MAX  = 3;
  localparam logic [21:0] DEF_ROM_TOP  = 22'h080000;

endpackage

// File: rtl/z88_memarb_prio.sv
// z88_memarb_prio
// Grant logic for the two SRAM requesters plus the video starvation counter.
// Ports:
//   clk, reset_n        : clock, synchronous active-low reset
//   i_arbEn             : sequencer is in IDLE and may start a transaction
//   i_cpuReq, i_cpuAck  : CPU request level and its current ack pulse
//   i_vidReq, i_vidAck  : video request level and its current ack pulse
//   o_grantCpu          : CPU wins this cycle (combinational)
//   o_grantVid          : video wins this cycle (combinational)
module z88_memarb_prio
  import z88_memarb_pkg::*;
#(
  parameter int VID_MAX = DEF_VID_MAX
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_arbEn,
  input  logic i_cpuReq,
  input  logic i_cpuAck,
  input  logic i_vidReq,
  input  logic i_vidAck,
  output logic o_grantCpu,
  output logic o_grantVid
);

  localparam int CNT_W = $clog2(VID_MAX + 1);

  logic [CNT_W-1:0] r_starve;
  logic             w_starved;

  assign w_starved = (r_starve == CNT_W'(VID_MAX));

  // A requester whose ack is showing this cycle is still holding its old
  // request, so it cannot be granted again. Its raw level still counts as
  // contention for video, which keeps a continuously requesting CPU from
  // losing to video on every ack cycle and leaves starvation to the counter.
  always_comb begin
    o_grantVid = i_arbEn && i_vidReq && !i_vidAck && (!i_cpuReq || w_starved);
    o_grantCpu = i_arbEn && i_cpuReq && !i_cpuAck && !o_grantVid;
  end

  // Counts CPU wins while video waits; saturates so video is forced in.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_starve <= '0;
    end else if (o_grantVid) begin
      r_starve <= '0;
    end else if (i_arbEn && !i_vidReq) begin
      r_starve <= '0;
    end else if (o_grantCpu && i_vidReq && !w_starved) begin
      r_starve <= r_starve + 1'b1;
    end
  end

endmodule

// File: rtl/z88_memarb.sv
// z88_memarb
// Slot-0 internal SRAM arbiter/sequencer shared by the CPU path and the
// screen fetch path. Turns level req/ack handshakes into timed asynchronous
// SRAM strobes. All outputs are registered.
// Optional build macro: Z88_MEMARB_WRPROT_EN adds write protection below
// ROM_TOP and the sticky wp_err output.
// Ports:
//   clk, reset_n                  : clock, synchronous active-low reset
//   cpu_req/cpu_we/cpu_a/cpu_wd   : CPU request (held until cpu_ack)
//   cpu_ack, cpu_rd               : CPU completion pulse and read data
//   vid_req/vid_a                 : video read request (held until vid_ack)
//   vid_ack, vid_rd               : video completion pulse and read data
//   mem_a/mem_wd/mem_rd           : SRAM address, write data, read data
//   mem_ce_n/mem_oe_n/mem_we_n    : SRAM strobes
//   wp_err                        : sticky protected-write flag (macro only)
//   busy                          : sequencer is not in IDLE
module z88_memarb
  import z88_memarb_pkg::*;
#(
  parameter int          ADDR_W   = DEF_ADDR_W,
  parameter int          RD_WAIT  = DEF_RD_WAIT,
  parameter int          WR_PULSE = DEF_WR_PULSE,
  parameter int          VID_MAX  = DEF_VID_MAX,
  parameter logic [21:0] ROM_TOP  = DEF_ROM_TOP
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [21:0]       cpu_a,
  input  logic [7:0]        cpu_wd,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rd,
  input  logic              vid_req,
  input  logic [21:0]       vid_a,
  output logic              vid_ack,
  output logic [7:0]        vid_rd,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_wd,
  input  logic [7:0]        mem_rd,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
`ifdef Z88_MEMARB_WRPROT_EN
  output logic              wp_err,
`endif
  output logic              busy
);

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_cnt;
  owner_t     r_owner;
  logic       r_we;
  logic       r_prot;

  logic w_grantCpu;
  logic w_grantVid;
  logic w_prot;
  logic w_ceN;
  logic w_oeN;
  logic w_weN;
  logic w_cpuAck;
  logic w_vidAck;
  logic w_busy;
  logic w_unused;

`ifdef Z88_MEMARB_WRPROT_EN
  assign w_prot   = (cpu_a < ROM_TOP);
  assign w_unused = ^vid_a[21:ADDR_W];
`else
  assign w_prot   = 1'b0;
  assign w_unused = ^{vid_a[21:ADDR_W], cpu_a[21:ADDR_W], ROM_TOP};
`endif

  z88_memarb_prio #(
    .VID_MAX(VID_MAX)
  ) u_prio (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_arbEn   (r_state == IDLE),
    .i_cpuReq  (cpu_req),
    .i_cpuAck  (cpu_ack),
    .i_vidReq  (vid_req),
    .i_vidAck  (vid_ack),
    .o_grantCpu(w_grantCpu),
    .o_grantVid(w_grantVid)
  );

  // State register; r_cnt counts cycles spent in the current timed state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_nextState != r_state || w_nextState == IDLE) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_grantVid) begin
          w_nextState = RD;
        end else if (w_grantCpu) begin
          w_nextState = cpu_we ? WSETUP : RD;
        end
      end
      RD: begin
        if (r_cnt == 8'(RD_WAIT - 1)) w_nextState = IDLE;
      end
      WSETUP: w_nextState = WPULSE;
      WPULSE: begin
        if (r_cnt == 8'(WR_PULSE - 1)) w_nextState = WHOLD;
      end
      WHOLD:   w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Output values are decoded from the next state so that the registered
  // strobes line up with the state they belong to.
  always_comb begin
    w_ceN    = (w_nextState == IDLE);
    w_oeN    = (w_nextState != RD);
    w_weN    = !((w_nextState == WPULSE) && !r_prot);
    w_busy   = (w_nextState != IDLE);
    w_cpuAck = 1'b0;
    w_vidAck = 1'b0;
    if (w_nextState == IDLE && (r_state == RD || r_state == WHOLD)) begin
      w_cpuAck = (r_owner == OWN_CPU);
      w_vidAck = (r_owner == OWN_VID);
    end
  end

  // Output registers, request latch on grant and read data capture at the
  // end of the last RD cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_ce_n <= 1'b1;
      mem_oe_n <= 1'b1;
      mem_we_n <= 1'b1;
      mem_a    <= '0;
      mem_wd   <= '0;
      cpu_ack  <= 1'b0;
      vid_ack  <= 1'b0;
      cpu_rd   <= 8'hFF;
      vid_rd   <= 8'hFF;
      busy     <= 1'b0;
      r_owner  <= OWN_CPU;
      r_we     <= 1'b0;
      r_prot   <= 1'b0;
`ifdef Z88_MEMARB_WRPROT_EN
      wp_err   <= 1'b0;
`endif
    end else begin
      mem_ce_n <= w_ceN;
      mem_oe_n <= w_oeN;
      mem_we_n <= w_weN;
      cpu_ack  <= w_cpuAck;
      vid_ack  <= w_vidAck;
      busy     <= w_busy;
      if (w_grantVid) begin
        r_owner <= OWN_VID;
        r_we    <= 1'b0;
        r_prot  <= 1'b0;
        mem_a   <= vid_a[ADDR_W-1:0];
      end else if (w_grantCpu) begin
        r_owner <= OWN_CPU;
        r_we    <= cpu_we;
        r_prot  <= cpu_we && w_prot;
        mem_a   <= cpu_a[ADDR_W-1:0];
        mem_wd  <= cpu_wd;
      end
      if (r_state == RD && w_nextState == IDLE) begin
        if (r_owner == OWN_CPU) begin
          cpu_rd <= mem_rd;
        end else begin
          vid_rd <= mem_rd;
        end
      end
`ifdef Z88_MEMARB_WRPROT_EN
      if (w_cpuAck && r_we && r_prot) wp_err <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_z88_memarb.sv
// tb_z88_memarb
// Directed self-checking bench for z88_memarb with default parameters.
// Inputs change just after the falling edge; outputs are checked on the
// falling edge. Cycle 0 is the IDLE cycle in which a request is raised.
module tb_z88_memarb;

  logic        clk;
  logic        reset_n;
  logic        cpuReq;
  logic        cpuWe;
  logic [21:0] cpuA;
  logic [7:0]  cpuWd;
  logic        cpuAck;
  logic [7:0]  cpuRd;
  logic        vidReq;
  logic [21:0] vidA;
  logic        vidAck;
  logic [7:0]  vidRd;
  logic [18:0] memA;
  logic [7:0]  memWd;
  logic [7:0]  memRd;
  logic        memCeN;
  logic        memOeN;
  logic        memWeN;
  logic        busy;
`ifdef Z88_MEMARB_WRPROT_EN
  logic        wpErr;
`endif

  int assertCount = 0;
  int failCount   = 0;

  z88_memarb dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cpu_req (cpuReq),
    .cpu_we  (cpuWe),
    .cpu_a   (cpuA),
    .cpu_wd  (cpuWd),
    .cpu_ack (cpuAck),
    .cpu_rd  (cpuRd),
    .vid_req (vidReq),
    .vid_a   (vidA),
    .vid_ack (vidAck),
    .vid_rd  (vidRd),
    .mem_a   (memA),
    .mem_wd  (memWd),
    .mem_rd  (memRd),
    .mem_ce_n(memCeN),
    .mem_oe_n(memOeN),
    .mem_we_n(memWeN),
`ifdef Z88_MEMARB_WRPROT_EN
    .wp_err  (wpErr),
`endif
    .busy    (busy)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic cReq, input logic cWe,
                               input logic [21:0] cA, input logic [7:0] cWd,
                               input logic vReq, input logic [21:0] vA);
    cpuReq = cReq;
    cpuWe  = cWe;
    cpuA   = cA;
    cpuWd  = cWd;
    vidReq = vReq;
    vidA   = vA;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one CPU write from cycle 0 and checks strobes through the ack.
  task automatic cpuWrite(input string tag, input logic [21:0] addr,
                          input logic [7:0] data, input logic prot);
    applyStimulus(1'b1, 1'b1, addr, data, 1'b0, 22'h0);
    for (int k = 1; k <= 5; k++) begin
      nextCycle();
      checkOutput($sformatf("%s_ce_c%0d", tag, k), 32'(memCeN), (k <= 4) ? 32'd0 : 32'd1);
      checkOutput($sformatf("%s_we_c%0d", tag, k), 32'(memWeN),
                  ((k == 2 || k == 3) && !prot) ? 32'd0 : 32'd1);
      checkOutput($sformatf("%s_oe_c%0d", tag, k), 32'(memOeN), 32'd1);
      checkOutput($sformatf("%s_ack_c%0d", tag, k), 32'(cpuAck), (k == 5) ? 32'd1 : 32'd0);
      if (k == 1) begin
        checkOutput($sformatf("%s_wd", tag), 32'(memWd), 32'(data));
        checkOutput($sformatf("%s_addr", tag), 32'(memA), 32'(addr[18:0]));
      end
    end
    applyStimulus(1'b0, 1'b0, 22'h0, 8'h00, 1'b0, 22'h0);
  endtask

  initial begin
    int order[$];
    int expOrder[8];
    int cpuAckCnt;
    int vidAckCnt;
    int cpuAckAt;
    int vidAckAt;
    int sawAck;

    expOrder = '{0, 0, 0, 1, 0, 0, 0, 1};
    reset_n = 1'b0;
    memRd   = 8'h00;
    applyStimulus(1'b0, 1'b0, 22'h0, 8'h00, 1'b0, 22'h0);

    // Reset state.
    nextCycle();
    nextCycle();
    checkOutput("rst_ce", 32'(memCeN), 32'd1);
    checkOutput("rst_oe", 32'(memOeN), 32'd1);
    checkOutput("rst_we", 32'(memWeN), 32'd1);
    checkOutput("rst_mem_a", 32'(memA), 32'd0);
    checkOutput("rst_mem_wd", 32'(memWd), 32'd0);
    checkOutput("rst_cpu_ack", 32'(cpuAck), 32'd0);
    checkOutput("rst_vid_ack", 32'(vidAck), 32'd0);
    checkOutput("rst_cpu_rd", 32'(cpuRd), 32'hFF);
    checkOutput("rst_vid_rd", 32'(vidRd), 32'hFF);
    checkOutput("rst_busy", 32'(busy), 32'd0);
`ifdef Z88_MEMARB_WRPROT_EN
    checkOutput("rst_wp_err", 32'(wpErr), 32'd0);
`endif
    reset_n = 1'b1;
    nextCycle();

    // CPU read: oe_n low cycles 1-2, ack with data in cycle 3.
    memRd = 8'hA5;
    applyStimulus(1'b1, 1'b0, 22'h0801F3, 8'h00, 1'b0, 22'h0);
    for (int k = 1; k <= 3; k++) begin
      nextCycle();
      checkOutput($sformatf("rd_oe_c%0d", k), 32'(memOeN), (k <= 2) ? 32'd0 : 32'd1);
      checkOutput($sformatf("rd_ce_c%0d", k), 32'(memCeN), (k <= 2) ? 32'd0 : 32'd1);
      checkOutput($sformatf("rd_ack_c%0d", k), 32'(cpuAck), (k == 3) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rd_busy_c%0d", k), 32'(busy), (k <= 2) ? 32'd1 : 32'd0);
      if (k == 1) checkOutput("rd_mem_a", 32'(memA), 32'h001F3);
    end
    checkOutput("rd_cpu_rd", 32'(cpuRd), 32'hA5);
    applyStimulus(1'b0, 1'b0, 22'h0, 8'h00, 1'b0, 22'h0);
    memRd = 8'h11;
    nextCycle();
    checkOutput("rd_ack_once", 32'(cpuAck), 32'd0);
    checkOutput("rd_cpu_rd_held", 32'(cpuRd), 32'hA5);

    // CPU write to an unprotected address.
    cpuWrite("wr", 22'h080010, 8'h3C, 1'b0);
    nextCycle();

    // Both held high: starvation guard forces every fourth grant to video.
    memRd = 8'h5A;
    applyStimulus(1'b1, 1'b0, 22'h000100, 8'h00, 1'b1, 22'h000200);
    for (int c = 0; c < 80 && order.size() < 8; c++) begin
      nextCycle();
      if (cpuAck) order.push_back(0);
      if (vidAck) order.push_back(1);
    end
    applyStimulus(1'b0, 1'b0, 22'h0, 8'h00, 1'b0, 22'h0);
    checkOutput("starve_ack_count", 32'(order.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("starve_order%0d", i),
                  (i < order.size()) ? 32'(order[i]) : 32'd9, 32'(expOrder[i]));
    end
    checkOutput("starve_vid_rd", 32'(vidRd), 32'h5A);
    nextCycle();
    nextCycle();
    checkOutput("starve_idle", 32'(busy), 32'd0);

    // Simultaneous requests that drop right after their own ack.
    memRd = 8'hC3;
    cpuAckCnt = 0;
    vidAckCnt = 0;
    cpuAckAt  = -1;
    vidAckAt  = -1;
    applyStimulus(1'b1, 1'b0, 22'h000123, 8'h00, 1'b1, 22'h000456);
    for (int c = 1; c <= 20; c++) begin
      nextCycle();
      if (cpuAck) begin
        cpuAckCnt++;
        cpuAckAt = c;
        cpuReq   = 1'b0;
      end
      if (vidAck) begin
        vidAckCnt++;
        vidAckAt = c;
        vidReq   = 1'b0;
      end
    end
    checkOutput("drop_cpu_acks", 32'(cpuAckCnt), 32'd1);
    checkOutput("drop_vid_acks", 32'(vidAckCnt), 32'd1);
    checkOutput("drop_cpu_ack_cycle", 32'(cpuAckAt), 32'd3);
    checkOutput("drop_vid_ack_cycle", 32'(vidAckAt), 32'd6);
    checkOutput("drop_vid_rd", 32'(vidRd), 32'hC3);

    // Reset during the first WPULSE cycle aborts without an ack.
    applyStimulus(1'b1, 1'b1, 22'h0A0000, 8'h99, 1'b0, 22'h0);
    nextCycle();
    nextCycle();
    checkOutput("abort_we_c2", 32'(memWeN), 32'd0);
    reset_n = 1'b0;
    nextCycle();
    checkOutput("abort_ce", 32'(memCeN), 32'd1);
    checkOutput("abort_oe", 32'(memOeN), 32'd1);
    checkOutput("abort_we", 32'(memWeN), 32'd1);
    checkOutput("abort_ack", 32'(cpuAck), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 1'b0, 22'h0, 8'h00, 1'b0, 22'h0);
    reset_n = 1'b1;
    sawAck = 0;
    for (int c = 0; c < 6; c++) begin
      nextCycle();
      if (cpuAck || busy) sawAck++;
    end
    checkOutput("abort_no_retry", 32'(sawAck), 32'd0);

    // Write below ROM_TOP: strobed normally unless write protection is built.
`ifdef Z88_MEMARB_WRPROT_EN
    cpuWrite("wp", 22'h000100, 8'h77, 1'b1);
    checkOutput("wp_err_set", 32'(wpErr), 32'd1);
    nextCycle();
    nextCycle();
    checkOutput("wp_err_sticky", 32'(wpErr), 32'd1);
`else
    cpuWrite("low", 22'h000100, 8'h77, 1'b0);
    nextCycle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
